// File: rtl/framebuffer_rect_command_handler.sv
// Framebuffer command engine: commit streams RAM words over AXIS,
// memset clears the scissor-clipped rectangle with per-pixel masks.
module framebuffer_rect_command_handler #(
  parameter int NUMBER_OF_PIXELS_PER_BEAT = 4,
  parameter int NUMBER_OF_SUB_PIXELS = 4,
  parameter int SUB_PIXEL_WIDTH = 8,
  parameter int X_BIT_WIDTH = 11,
  parameter int Y_BIT_WIDTH = 11,
  parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
  parameter int FB_SIZE_IN_PIXEL_LG = 20,
  localparam int PPB = NUMBER_OF_PIXELS_PER_BEAT,
  localparam int NSP = NUMBER_OF_SUB_PIXELS,
  localparam int PW = NSP * SUB_PIXEL_WIDTH,
  localparam int LG = $clog2(PPB),
  localparam int AW = FRAMEBUFFER_SIZE_IN_PIXEL_LG - LG,
  localparam int XW = X_BIT_WIDTH,
  localparam int YW = Y_BIT_WIDTH,
  localparam int SZW = FB_SIZE_IN_PIXEL_LG
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PW-1:0]       confClearColor,
  input  logic                confEnableScissor,
  input  logic [XW-1:0]       confScissorStartX,
  input  logic [XW-1:0]       confScissorEndX,
  input  logic [YW-1:0]       confScissorStartY,
  input  logic [YW-1:0]       confScissorEndY,
  input  logic [YW-1:0]       confYOffset,
  input  logic [XW-1:0]       confXResolution,
  input  logic [YW-1:0]       confYResolution,
  input  logic [NSP-1:0]      confMask,
  input  logic                apply,
  output logic                applied,
  input  logic                cmdCommit,
  input  logic                cmdMemset,
  input  logic [SZW-1:0]      cmdSize,
  output logic [PPB*PW-1:0]   writeDataPort,
  output logic                writeEnablePort,
  output logic [AW-1:0]       writeAddrPort,
  output logic [PPB*NSP-1:0]  writeMaskPort,
  output logic [AW-1:0]       readAddrPort,
  input  logic [PPB*PW-1:0]   readDataPort,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [PPB*PW-1:0]   m_axis_tdata
);
  localparam int BW = SZW + 1 - LG;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] COMMIT = 2'd1;
  localparam logic [1:0] MSETUP = 2'd2;
  localparam logic [1:0] MEMSET = 2'd3;

  logic [1:0]    state;
  logic          c_commit, c_memset, scissor;
  logic [BW-1:0] beats_total, rd_cnt, tx_cnt;
  logic [PW-1:0] clear;
  logic [XW-1:0] sx0, sx1, xres;
  logic [YW-1:0] sy0, sy1, yoff, yres;
  logic [NSP-1:0] mask;

  logic [AW-1:0]     rd_addr;
  logic [PPB*PW-1:0] buf0, buf1;
  logic              wp, rp, inflight;
  logic [1:0]        cnt;
  logic              pop, issue, room;

  logic [XW-1:0] x_lo, x_hi, bx, bx_lo, bx_hi;
  logic [YW:0]   y_lo, y_hi, y_cur;
  logic [AW-1:0] row_base, stride;

  logic [XW-1:0] x_lo_c, x_hi_c;
  logic [YW:0]   y_lo_c, y_hi_c, y_end;
  logic          empty;

  assign pop = m_axis_tvalid && m_axis_tready;
  // Reserve a slot for the read already in flight.
  assign room = ({1'b0, cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
  assign issue = (state == COMMIT) && c_commit && (rd_cnt != beats_total) && room;

  assign readAddrPort = rd_addr;
  assign m_axis_tvalid = cnt != 2'd0;
  assign m_axis_tdata = rp ? buf1 : buf0;
  assign m_axis_tlast = m_axis_tvalid && (tx_cnt == beats_total - BW'(1));

  assign y_end = {1'b0, yoff} + {1'b0, yres};
  assign x_lo_c = scissor ? sx0 : '0;
  assign x_hi_c = (scissor && sx1 < xres) ? sx1 : xres;
  assign y_lo_c = (scissor && sy0 > yoff) ? {1'b0, sy0} : {1'b0, yoff};
  assign y_hi_c = (scissor && {1'b0, sy1} < y_end) ? {1'b0, sy1} : y_end;
  assign empty = (x_lo_c >= x_hi_c) || (y_lo_c >= y_hi_c);

  assign writeEnablePort = (state == MEMSET) && (y_cur >= y_lo);
  assign writeAddrPort = row_base + AW'(bx);
  assign writeDataPort = {PPB{clear}};

  always_comb begin
    logic [XW:0] px;
    writeMaskPort = '0;
    for (int p = 0; p < PPB; p++) begin
      px = ({1'b0, bx} << LG) + (XW + 1)'(p);
      if (px >= {1'b0, x_lo} && px < {1'b0, x_hi})
        writeMaskPort[p*NSP +: NSP] = mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      applied <= 1'b1;
      cnt <= '0;
      inflight <= 1'b0;
      wp <= 1'b0;
      rp <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rd_addr <= rd_addr + AW'(1);
        rd_cnt <= rd_cnt + BW'(1);
      end
      if (inflight) begin
        if (wp) buf1 <= readDataPort;
        else buf0 <= readDataPort;
        wp <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
        tx_cnt <= tx_cnt + BW'(1);
      end
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};

      unique case (state)
        IDLE: if (apply && applied) begin
          applied <= 1'b0;
          state <= COMMIT;
          c_commit <= cmdCommit;
          c_memset <= cmdMemset;
          beats_total <= BW'(({1'b0, cmdSize} + (SZW + 1)'(PPB - 1)) >> LG);
          clear <= confClearColor;
          scissor <= confEnableScissor;
          sx0 <= confScissorStartX;
          sx1 <= confScissorEndX;
          sy0 <= confScissorStartY;
          sy1 <= confScissorEndY;
          yoff <= confYOffset;
          xres <= confXResolution;
          yres <= confYResolution;
          mask <= confMask;
          rd_addr <= '0;
          rd_cnt <= '0;
          tx_cnt <= '0;
        end
        COMMIT: begin
          if (!c_commit || beats_total == '0) begin
            state <= MSETUP;
          end else if (pop && m_axis_tlast) begin
            state <= c_memset ? MSETUP : IDLE;
            applied <= !c_memset;
          end
        end
        MSETUP: begin
          if (!c_memset || empty) begin
            state <= IDLE;
            applied <= 1'b1;
          end else begin
            state <= MEMSET;
            x_lo <= x_lo_c;
            x_hi <= x_hi_c;
            y_lo <= y_lo_c;
            y_hi <= y_hi_c;
            bx <= x_lo_c >> LG;
            bx_lo <= x_lo_c >> LG;
            bx_hi <= (x_hi_c - XW'(1)) >> LG;
            y_cur <= {1'b0, yoff};
            row_base <= '0;
            stride <= AW'(xres >> LG);
          end
        end
        MEMSET: begin
          // Rows above the clip window only advance the row base.
          if (y_cur < y_lo || bx == bx_hi) begin
            bx <= bx_lo;
            y_cur <= y_cur + (YW + 1)'(1);
            row_base <= row_base + stride;
            if (y_cur >= y_lo && y_cur + (YW + 1)'(1) == y_hi) begin
              state <= IDLE;
              applied <= 1'b1;
            end
          end else begin
            bx <= bx + XW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_framebuffer_rect_command_handler.sv
// Scoreboard bench: pixel-level reference model feeds expected RAM
// writes and AXIS beats; a negedge monitor pops and compares them.
module tb_framebuffer_rect_command_handler;
  localparam int PPB = 4;
  localparam int NSP = 4;
  localparam int PW = 32;
  localparam int XW = 11;
  localparam int YW = 11;
  localparam int AW = 16;
  localparam int SZW = 20;

  logic clk = 0;
  logic reset = 1;
  logic [PW-1:0] confClearColor = '0;
  logic confEnableScissor = 0;
  logic [XW-1:0] confScissorStartX = '0, confScissorEndX = '0;
  logic [YW-1:0] confScissorStartY = '0, confScissorEndY = '0;
  logic [YW-1:0] confYOffset = '0, confYResolution = '0;
  logic [XW-1:0] confXResolution = '0;
  logic [NSP-1:0] confMask = '0;
  logic apply = 0, applied;
  logic cmdCommit = 0, cmdMemset = 0;
  logic [SZW-1:0] cmdSize = '0;
  logic [PPB*PW-1:0] writeDataPort, readDataPort = '0, m_axis_tdata;
  logic writeEnablePort;
  logic [AW-1:0] writeAddrPort, readAddrPort;
  logic [PPB*NSP-1:0] writeMaskPort;
  logic m_axis_tvalid, m_axis_tready = 0, m_axis_tlast;

  framebuffer_rect_command_handler dut (
    .clk(clk), .reset(reset),
    .confClearColor(confClearColor),
    .confEnableScissor(confEnableScissor),
    .confScissorStartX(confScissorStartX),
    .confScissorEndX(confScissorEndX),
    .confScissorStartY(confScissorStartY),
    .confScissorEndY(confScissorEndY),
    .confYOffset(confYOffset),
    .confXResolution(confXResolution),
    .confYResolution(confYResolution),
    .confMask(confMask),
    .apply(apply), .applied(applied),
    .cmdCommit(cmdCommit), .cmdMemset(cmdMemset),
    .cmdSize(cmdSize),
    .writeDataPort(writeDataPort),
    .writeEnablePort(writeEnablePort),
    .writeAddrPort(writeAddrPort),
    .writeMaskPort(writeMaskPort),
    .readAddrPort(readAddrPort),
    .readDataPort(readDataPort),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [PPB*NSP-1:0] mask;
    logic [PPB*PW-1:0] data;
  } wr_t;
  typedef struct {
    logic [PPB*PW-1:0] data;
    logic last;
  } bt_t;

  wr_t exp_wr[$];
  bt_t exp_bt[$];
  int n_checks = 0;
  int n_fail = 0;
  int rmode = 2;

  function automatic logic [PPB*PW-1:0] ram_word(input logic [AW-1:0] a);
    logic [PPB*PW-1:0] w;
    for (int p = 0; p < PPB; p++)
      w[p*PW +: PW] = (32'(a) * PPB + p) * 32'h9E3779B1 ^ 32'h5A5A0000;
    return w;
  endfunction

  always @(posedge clk) readDataPort <= ram_word(readAddrPort);

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0: m_axis_tready = ~m_axis_tready;
      1: m_axis_tready = 1'($urandom_range(0, 1));
      2: m_axis_tready = 1'b1;
      default: m_axis_tready = 1'b0;
    endcase
  end

  logic prev_v = 0, prev_r = 0, prev_l = 0;
  logic [PPB*PW-1:0] prev_d = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_v = 0;
    end else begin
      if (prev_v && !prev_r) begin
        check("tvalid_held", m_axis_tvalid, 1'b1);
        check("tdata_held", m_axis_tdata, prev_d);
        check("tlast_held", m_axis_tlast, prev_l);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_bt.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat: got data %0h expected no beat", m_axis_tdata);
        end else begin
          bt_t e;
          e = exp_bt.pop_front();
          check("beat_data", m_axis_tdata, e.data);
          check("beat_last", m_axis_tlast, e.last);
        end
      end
      if (writeEnablePort) begin
        check("beats_before_write", exp_bt.size(), 0);
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_write: got addr %0h expected no write", writeAddrPort);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("write_addr", writeAddrPort, e.addr);
          check("write_mask", writeMaskPort, e.mask);
          check("write_data", writeDataPort, e.data);
        end
      end
      prev_v = m_axis_tvalid;
      prev_r = m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
    end
  end

  task automatic model_commit(input int size);
    int beats;
    beats = (size + PPB - 1) / PPB;
    for (int i = 0; i < beats; i++) begin
      bt_t b;
      b.data = ram_word(AW'(i));
      b.last = (i == beats - 1);
      exp_bt.push_back(b);
    end
  endtask

  task automatic model_memset();
    int xr, bpr, y;
    bit sc, any;
    xr = int'(confXResolution);
    bpr = xr / PPB;
    sc = confEnableScissor;
    for (int r = 0; r < int'(confYResolution); r++) begin
      y = int'(confYOffset) + r;
      if (sc && (y < int'(confScissorStartY) || y >= int'(confScissorEndY))) continue;
      for (int b = 0; b < bpr; b++) begin
        wr_t w;
        any = 0;
        w.mask = '0;
        for (int p = 0; p < PPB; p++) begin
          int x;
          x = b * PPB + p;
          if (!sc || (x >= int'(confScissorStartX) && x < int'(confScissorEndX))) begin
            any = 1;
            w.mask[p*NSP +: NSP] = confMask;
          end
        end
        if (any) begin
          w.addr = AW'(r * bpr + b);
          w.data = {PPB{confClearColor}};
          exp_wr.push_back(w);
        end
      end
    end
  endtask

  task automatic set_conf(input bit sc, input int sx0, sx1, sy0, sy1,
                          input int yo, xr, yr, input logic [31:0] clr,
                          input logic [3:0] m);
    confEnableScissor = sc;
    confScissorStartX = XW'(sx0);
    confScissorEndX = XW'(sx1);
    confScissorStartY = YW'(sy0);
    confScissorEndY = YW'(sy1);
    confYOffset = YW'(yo);
    confXResolution = XW'(xr);
    confYResolution = YW'(yr);
    confClearColor = clr;
    confMask = m;
  endtask

  task automatic run_cmd(input bit c, input bit m, input int size,
                         input bit busy_apply, output int low);
    if (c) model_commit(size);
    if (m) model_memset();
    @(posedge clk);
    #1;
    cmdCommit = c;
    cmdMemset = m;
    cmdSize = SZW'(size);
    apply = 1;
    @(posedge clk);
    #1;
    apply = 0;
    confClearColor = $urandom;
    confMask = 4'($urandom);
    confScissorStartX = '0;
    confYOffset = YW'($urandom_range(0, 3));
    low = 0;
    while (!applied && low < 3000) begin
      if (busy_apply && low == 1) begin
        apply = 1;
        cmdMemset = 1;
        cmdCommit = 1;
      end
      @(posedge clk);
      #1;
      apply = 0;
      low++;
    end
    check("applied_returns", applied, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("applied_stays", applied, 1'b1);
    check("writes_pending", exp_wr.size(), 0);
    check("beats_pending", exp_bt.size(), 0);
    exp_wr.delete();
    exp_bt.delete();
  endtask

  initial begin
    int low;
    repeat (3) @(posedge clk);
    #1;
    check("reset_applied", applied, 1'b1);
    check("reset_tvalid", m_axis_tvalid, 1'b0);
    check("reset_we", writeEnablePort, 1'b0);
    reset = 0;

    rmode = 2;
    set_conf(0, 0, 0, 0, 0, 0, 8, 2, 32'hAABBCCDD, 4'hF);
    run_cmd(0, 1, 0, 0, low);

    set_conf(1, 2, 7, 1, 2, 0, 8, 4, 32'h11223344, 4'hF);
    run_cmd(0, 1, 0, 0, low);

    rmode = 0;
    run_cmd(1, 0, 16, 0, low);

    rmode = 1;
    set_conf(0, 0, 0, 0, 0, 0, 8, 2, 32'hCAFEF00D, 4'b0001);
    run_cmd(1, 1, 13, 0, low);

    set_conf(1, 0, 8, 0, 5, 8, 8, 4, 32'h0, 4'hF);
    run_cmd(0, 1, 0, 1, low);
    check("disjoint_quick", low <= 3, 1'b1);

    run_cmd(0, 0, 0, 0, low);
    check("noop_two_cycles", low, 2);

    run_cmd(1, 0, 0, 0, low);

    for (int i = 0; i < 25; i++) begin
      int xr, yo;
      xr = PPB * $urandom_range(1, 8);
      yo = $urandom_range(0, 6);
      rmode = $urandom_range(0, 2);
      set_conf(1'($urandom_range(0, 1)), $urandom_range(0, xr + 2),
               $urandom_range(0, xr + 4), $urandom_range(0, yo + 6),
               $urandom_range(0, yo + 9), yo, xr, $urandom_range(1, 6),
               $urandom, 4'($urandom_range(1, 15)));
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 40), 1'($urandom_range(0, 1)), low);
    end

    rmode = 3;
    model_commit(16);
    @(posedge clk);
    #1;
    cmdCommit = 1;
    cmdMemset = 0;
    cmdSize = SZW'(16);
    apply = 1;
    @(posedge clk);
    #1;
    apply = 0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    exp_bt.delete();
    check("midreset_applied", applied, 1'b1);
    check("midreset_tvalid", m_axis_tvalid, 1'b0);
    check("midreset_we", writeEnablePort, 1'b0);
    rmode = 2;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("midreset_no_beats", m_axis_tvalid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
